// File: rtl/store_write_buffer.sv
// store_write_buffer: post-commit store FIFO between the ROB store port and the dcache write port,
// with a same-word load conflict check and full-word store-to-load forwarding.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic        dcache_write,
  output logic [31:0] dcache_address,
  output logic [31:0] dcache_wdata,
  output logic [3:0]  dcache_byte_enable,
  input  logic        dcache_resp,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [3:0]    be_d   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [AW:0]   count_q, count_d;
  logic          mem_resp_q, mem_resp_d, push, pop;
  always_comb begin
    push       = mem_write && !mem_resp_q && (count_q != FULL);
    pop        = (count_q != '0) && dcache_resp;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    if (push) begin
      addr_d[wr_ptr_q] = mem_address;
      data_d[wr_ptr_q] = mem_wdata;
      be_d[wr_ptr_q]   = mem_byte_enable;
    end
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    mem_resp_d = push;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_resp_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_resp_q <= mem_resp_d;
    end
  end
  assign mem_resp           = mem_resp_q;
  assign empty              = (count_q == '0);
  assign dcache_write       = !empty;
  assign dcache_address     = dcache_write ? addr_q[rd_ptr_q] : '0;
  assign dcache_wdata       = dcache_write ? data_q[rd_ptr_q] : '0;
  assign dcache_byte_enable = dcache_write ? be_q[rd_ptr_q] : '0;
  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    ld_conflict  = 1'b0;
    ld_fwd_valid = 1'b0;
    ld_fwd_data  = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (ld_valid && ((AW+1)'(i) < count_q) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
        ld_conflict  = 1'b1;
        ld_fwd_valid = (be_q[idx] == 4'hF);
        ld_fwd_data  = (be_q[idx] == 4'hF) ? data_q[idx] : '0;
      end
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed scenario tasks with hand-computed expectations for store_write_buffer.
module tb_store_write_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic        mem_resp;
  logic        dcache_write;
  logic [31:0] dcache_address;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_byte_enable;
  logic        dcache_resp = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_conflict;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        empty;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] seen [$];

  store_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .dcache_write(dcache_write), .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_byte_enable(dcache_byte_enable), .dcache_resp(dcache_resp),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_en && dcache_write && dcache_resp) seen.push_back(dcache_wdata);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, output bit ok);
    mem_write = 1'b1; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_resp) begin ok = 1'b1; break; end
    end
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    ld_valid = 1'b1; ld_addr = 32'h0;
    #1;
    n_checks++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp got %0b want 0", mem_resp); end
    n_checks++; if (dcache_write !== 1'b0) begin n_fail++; $display("FAIL reset_dcache_write got %0b want 0", dcache_write); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
    n_checks++; if ({dcache_address, dcache_wdata, dcache_byte_enable} !== 68'h0) begin n_fail++; $display("FAIL reset_dcache_fields got %h/%h/%h want 0", dcache_address, dcache_wdata, dcache_byte_enable); end
    n_checks++; if ({ld_conflict, ld_fwd_valid, ld_fwd_data} !== 34'h0) begin n_fail++; $display("FAIL reset_ld got %b/%b/%h want 0", ld_conflict, ld_fwd_valid, ld_fwd_data); end
    ld_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    mem_write = 1'b1; mem_address = 32'h100; mem_wdata = 32'hDEADBEEF; mem_byte_enable = 4'hF;
    n_checks++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL single_resp_early got %0b want 0", mem_resp); end
    step();
    n_checks++; if (mem_resp !== 1'b1) begin n_fail++; $display("FAIL single_resp got %0b want 1", mem_resp); end
    n_checks++; if ({dcache_write, dcache_address, dcache_wdata, dcache_byte_enable} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF})
      begin n_fail++; $display("FAIL single_dcache got %b/%h/%h/%h want 1/100/deadbeef/f", dcache_write, dcache_address, dcache_wdata, dcache_byte_enable); end
    step();
    n_checks++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL single_resp_pulse got %0b want 0", mem_resp); end
    mem_write = 1'b0;
    step();
    n_checks++; if (mem_resp !== 1'b0 || dut.count_q !== 3'd1) begin n_fail++; $display("FAIL single_no_dup resp %0b count %0d want 0/1", mem_resp, dut.count_q); end
    dcache_resp = 1'b1;
    step();
    dcache_resp = 1'b0;
    n_checks++; if (empty !== 1'b1 || dcache_write !== 1'b0) begin n_fail++; $display("FAIL single_drain empty %0b dwrite %0b want 1/0", empty, dcache_write); end
  endtask

  task automatic test_fill();
    bit ok;
    bit saw;
    logic [31:0] exp [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) begin
      push_store(32'h10 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_push%0d got no mem_resp want resp", i); end
    end
    mem_write = 1'b1; mem_address = 32'h20; mem_wdata = 32'hA4; mem_byte_enable = 4'hF;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); saw |= mem_resp; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL fill_full_blocks got resp %0b want 0", saw); end
    dcache_resp = 1'b1;
    step();
    dcache_resp = 1'b0;
    saw = mem_resp;
    if (!saw) begin step(); saw = mem_resp; end
    n_checks++; if (saw !== 1'b1) begin n_fail++; $display("FAIL fill_resp_after_pop got %0b want 1 within 2", saw); end
    mem_write = 1'b0;
    dcache_resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (dcache_write !== 1'b1 || dcache_wdata !== exp[k]) begin n_fail++; $display("FAIL fill_order%0d got %b/%h want 1/%h", k, dcache_write, dcache_wdata, exp[k]); end
      step();
    end
    dcache_resp = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty got %0b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    seen.delete();
    mon_en = 1'b1;
    dcache_resp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_store(32'h300 + 32'(4*i), 32'hB0 + 32'(i), 4'hF, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_push%0d got no mem_resp want resp", i); end
    end
    step(); step();
    mon_en = 1'b0;
    dcache_resp = 1'b0;
    n_checks++; if (seen.size() != 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", seen.size()); end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      n_checks++; if (seen[i] !== 32'hB0 + 32'(i)) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, seen[i], 32'hB0 + 32'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %0b want 1", empty); end
  endtask

  task automatic test_forward();
    bit ok;
    push_store(32'h200, 32'h11111111, 4'hF, ok);
    push_store(32'h200, 32'h22222222, 4'hF, ok);
    ld_valid = 1'b1; ld_addr = 32'h202;
    #1;
    n_checks++; if ({ld_conflict, ld_fwd_valid, ld_fwd_data} !== {2'b11, 32'h22222222}) begin n_fail++; $display("FAIL fwd_youngest got %b/%b/%h want 1/1/22222222", ld_conflict, ld_fwd_valid, ld_fwd_data); end
    ld_addr = 32'h204;
    #1;
    n_checks++; if ({ld_conflict, ld_fwd_valid, ld_fwd_data} !== 34'h0) begin n_fail++; $display("FAIL fwd_miss got %b/%b/%h want 0/0/0", ld_conflict, ld_fwd_valid, ld_fwd_data); end
    ld_addr = 32'h200; ld_valid = 1'b0;
    #1;
    n_checks++; if ({ld_conflict, ld_fwd_valid, ld_fwd_data} !== 34'h0) begin n_fail++; $display("FAIL fwd_invalid got %b/%b/%h want 0/0/0", ld_conflict, ld_fwd_valid, ld_fwd_data); end
    dcache_resp = 1'b1;
    step();
    dcache_resp = 1'b0;
    push_store(32'h200, 32'h33, 4'b0001, ok);
    ld_valid = 1'b1; ld_addr = 32'h202;
    #1;
    n_checks++; if ({ld_conflict, ld_fwd_valid, ld_fwd_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL fwd_partial got %b/%b/%h want 1/0/0", ld_conflict, ld_fwd_valid, ld_fwd_data); end
    ld_valid = 1'b0;
    dcache_resp = 1'b1;
    step(); step();
    dcache_resp = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drain got %0b want 1", empty); end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int i = 0; i < 3; i++) push_store(32'h400 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, ok);
    n_checks++; if (dcache_write !== 1'b1 || dcache_wdata !== 32'hC0) begin n_fail++; $display("FAIL areset_pre got %b/%h want 1/c0", dcache_write, dcache_wdata); end
    ld_valid = 1'b1; ld_addr = 32'h400;
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({mem_resp, dcache_write, empty} !== 3'b001) begin n_fail++; $display("FAIL areset_ctrl got resp %b dwrite %b empty %b want 0/0/1", mem_resp, dcache_write, empty); end
    n_checks++; if ({dcache_address, dcache_wdata, dcache_byte_enable, ld_conflict, ld_fwd_valid, ld_fwd_data} !== 102'h0)
      begin n_fail++; $display("FAIL areset_fields got %h/%h/%h ld %b/%b/%h want 0", dcache_address, dcache_wdata, dcache_byte_enable, ld_conflict, ld_fwd_valid, ld_fwd_data); end
    ld_valid = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    n_checks++; if (dcache_write !== 1'b0) begin n_fail++; $display("FAIL areset_stay_idle got %0b want 0", dcache_write); end
    push_store(32'h500, 32'hE0, 4'h3, ok);
    n_checks++; if ({ok, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable} !== {2'b11, 32'h500, 32'hE0, 4'h3})
      begin n_fail++; $display("FAIL areset_new_store got %b/%b/%h/%h/%h want 1/1/500/e0/3", ok, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_forward();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
